// File: rtl/evt_cnt_pkg.sv
// Shared definitions for the parametrised event counter bank: channel
// init-value function, read FSM state encoding and channel-count ceiling.
package evt_cnt_pkg;

    localparam int MAX_NCH = 64;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_HOLD = 1'b1
    } rd_state_e;

    // Init value of channel i: (base + i*stride) mod 2^width.
    // The tally only counts invocations; the result never depends on it,
    // so every call for a given channel yields the same value.
    function static logic [31:0] init_val(int i, int base, int stride, int width);
        static int tally = 0;
        longint sum;
        longint mask;
        tally = tally + 1;
        sum   = longint'(base) + longint'(i) * longint'(stride);
        mask  = (longint'(1) << width) - longint'(1);
        return 32'(sum & mask);
    endfunction

endpackage

// File: rtl/evt_cnt_chan.sv
// One event counter channel: clear/increment priority, wrap or saturate
// on overflow, and a sticky overflow flag.
module evt_cnt_chan
    import evt_cnt_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               SAT   = 0,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // Next count after one event: wraps to zero or sticks at all-ones.
    function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v);
        if (v != ALL_ONES) begin
            return v + 1'b1;
        end else if (SAT != 0) begin
            return v;
        end else begin
            return '0;
        end
    endfunction

    // Counter and sticky overflow; clear beats increment beats hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= INIT;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= INIT;
            ovf <= 1'b0;
        end else if (inc) begin
            cnt <= bump(cnt);
            if (cnt == ALL_ONES) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_evt_counter_bank.sv
// Bank of NCH event counters with elaboration-time init values and a
// registered single-channel valid/ready readback port.
module param_evt_counter_bank
    import evt_cnt_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int WIDTH  = 8,
    parameter  int BASE   = 1,
    parameter  int STRIDE = 16,
    parameter  int SAT    = 0,
    localparam int IDXW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   inc_i,
    input  logic [NCH-1:0]   clr_i,
    input  logic             rd_req_i,
    input  logic [IDXW-1:0]  rd_idx_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_err_o,
    output logic [NCH-1:0]   ovf_o
);

    // Two independent evaluations of channel 0's init value; they must agree.
    localparam logic [WIDTH-1:0] INIT0_A = WIDTH'(init_val(0, BASE, STRIDE, WIDTH));
    localparam logic [WIDTH-1:0] INIT0_B = WIDTH'(init_val(0, BASE, STRIDE, WIDTH));

    if (INIT0_A != INIT0_B) begin : g_init_chk
        $error("init_val is not repeatable: %0d vs %0d", INIT0_A, INIT0_B);
    end

    if (NCH < 1 || NCH > MAX_NCH) begin : g_nch_chk
        $error("NCH=%0d outside 1..%0d", NCH, MAX_NCH);
    end

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
        $error("WIDTH=%0d outside 2..32", WIDTH);
    end

    logic [WIDTH-1:0] cnt [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        evt_cnt_chan #(
            .WIDTH (WIDTH),
            .SAT   (SAT),
            .INIT  (WIDTH'(init_val(c, BASE, STRIDE, WIDTH)))
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_i[c]),
            .clr   (clr_i[c]),
            .cnt   (cnt[c]),
            .ovf   (ovf_o[c])
        );
    end

    // Channel select; an index with no matching channel reads as zero with error.
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (rd_idx_i == IDXW'(c)) begin
                sel_data = cnt[c];
                sel_err  = 1'b0;
            end
        end
    end

    rd_state_e state_q;
    rd_state_e state_d;
    logic      load;

    // Read FSM: capture on request when idle, or on request with ready in hold.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (rd_req_i) begin
                    load    = 1'b1;
                    state_d = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (rd_ready_i) begin
                    if (rd_req_i) begin
                        load = 1'b1;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    logic             vld_p1;
    logic [WIDTH-1:0] rd_data_p1;
    logic             rd_err_p1;

    // ---- stage p1: registered read response ----
    // State, valid flag and captured data; data is held until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
            rd_err_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= (state_d == RD_HOLD);
            if (load) begin
                rd_data_p1 <= sel_data;
                rd_err_p1  <= sel_err;
            end
        end
    end

    assign rd_valid_o = vld_p1;
    assign rd_data_o  = rd_data_p1;
    assign rd_err_o   = rd_err_p1;

endmodule

// File: tb/tb_param_evt_counter_bank.sv
// Directed bench for param_evt_counter_bank: a wrapping bank, a saturating
// bank and a three-channel bank share the clock, reset and read controls.
module tb_param_evt_counter_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] inc_a, clr_a, inc_s, clr_s;
    logic [2:0] inc_3, clr_3;
    logic       rd_req, rd_ready;
    logic [1:0] rd_idx;

    logic       vld_a, err_a, vld_s, err_s, vld_3, err_3;
    logic [7:0] dat_a, dat_s, dat_3;
    logic [3:0] ovf_a, ovf_s;
    logic [2:0] ovf_3;

    logic       r_vld_a, r_err_a, r_vld_s, r_err_s, r_vld_3, r_err_3;
    logic [7:0] r_dat_a, r_dat_s, r_dat_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_evt_counter_bank #(.NCH(4), .WIDTH(8), .BASE(1), .STRIDE(16), .SAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_a), .clr_i(clr_a),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_ready_i(rd_ready),
        .rd_valid_o(vld_a), .rd_data_o(dat_a), .rd_err_o(err_a), .ovf_o(ovf_a)
    );

    param_evt_counter_bank #(.NCH(4), .WIDTH(8), .BASE(1), .STRIDE(16), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_s), .clr_i(clr_s),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_ready_i(rd_ready),
        .rd_valid_o(vld_s), .rd_data_o(dat_s), .rd_err_o(err_s), .ovf_o(ovf_s)
    );

    param_evt_counter_bank #(.NCH(3), .WIDTH(8), .BASE(1), .STRIDE(16), .SAT(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_3), .clr_i(clr_3),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_ready_i(rd_ready),
        .rd_valid_o(vld_3), .rd_data_o(dat_3), .rd_err_o(err_3), .ovf_o(ovf_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read on all banks: latch the response one cycle after the request,
    // then release the request and let the FSMs return to idle.
    task automatic rd(input logic [1:0] idx);
        rd_req   = 1'b1;
        rd_idx   = idx;
        rd_ready = 1'b1;
        tick();
        r_vld_a = vld_a; r_dat_a = dat_a; r_err_a = err_a;
        r_vld_s = vld_s; r_dat_s = dat_s; r_err_s = err_s;
        r_vld_3 = vld_3; r_dat_3 = dat_3; r_err_3 = err_3;
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0;
        inc_a = '0; clr_a = '0; inc_s = '0; clr_s = '0; inc_3 = '0; clr_3 = '0;
        rd_req = 1'b0; rd_idx = '0; rd_ready = 1'b0;
        repeat (2) tick();
        checks++;
        if ({vld_a, err_a, dat_a, ovf_a} !== 14'd0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", {vld_a, err_a, dat_a, ovf_a});
        end
        checks++;
        if (dut.INIT0_A !== 8'd1 || dut.INIT0_B !== 8'd1) begin
            errors++; $display("FAIL init0_consts: got %0d/%0d required 1/1", dut.INIT0_A, dut.INIT0_B);
        end
        rst_n = 1'b1;
        tick();
        rd_req   = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            exp    = 8'(1 + 16 * i);
            tick();
            checks++;
            if (vld_a !== 1'b1 || dat_a !== exp || err_a !== 1'b0) begin
                errors++; $display("FAIL init_read[%0d]: got v=%b d=%0d e=%b required v=1 d=%0d e=0", i, vld_a, dat_a, err_a, exp);
            end
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (vld_a !== 1'b0 || dat_a !== 8'd49) begin
            errors++; $display("FAIL read_release: got v=%b d=%0d required v=0 d=49", vld_a, dat_a);
        end
    endtask

    task automatic test_wrap();
        inc_a = 4'b0001;
        repeat (254) tick();
        inc_a = '0;
        rd(2'd0);
        checks++;
        if (r_dat_a !== 8'd255 || ovf_a[0] !== 1'b0) begin
            errors++; $display("FAIL wrap_at_max: got d=%0d ovf=%b required d=255 ovf=0", r_dat_a, ovf_a[0]);
        end
        inc_a = 4'b0001;
        tick();
        inc_a = '0;
        rd(2'd0);
        checks++;
        if (r_dat_a !== 8'd0 || ovf_a !== 4'b0001) begin
            errors++; $display("FAIL wrap_to_zero: got d=%0d ovf=%b required d=0 ovf=0001", r_dat_a, ovf_a);
        end
        clr_a = 4'b0001;
        tick();
        clr_a = '0;
        checks++;
        if (ovf_a[0] !== 1'b0) begin
            errors++; $display("FAIL clr_ovf: got %b required 0", ovf_a[0]);
        end
        rd(2'd0);
        checks++;
        if (r_dat_a !== 8'd1) begin
            errors++; $display("FAIL clr_value: got %0d required 1", r_dat_a);
        end
    endtask

    task automatic test_saturate();
        inc_s = 4'b1000;
        repeat (206) tick();
        inc_s = '0;
        rd(2'd3);
        checks++;
        if (r_dat_s !== 8'd255 || ovf_s[3] !== 1'b0) begin
            errors++; $display("FAIL sat_reach_max: got d=%0d ovf=%b required d=255 ovf=0", r_dat_s, ovf_s[3]);
        end
        inc_s = 4'b1000;
        repeat (94) tick();
        inc_s = '0;
        rd(2'd3);
        checks++;
        if (r_dat_s !== 8'd255 || ovf_s !== 4'b1000) begin
            errors++; $display("FAIL sat_300: got d=%0d ovf=%b required d=255 ovf=1000", r_dat_s, ovf_s);
        end
        inc_s = 4'b1000;
        tick();
        inc_s = '0;
        rd(2'd3);
        checks++;
        if (r_dat_s !== 8'd255 || ovf_s[3] !== 1'b1) begin
            errors++; $display("FAIL sat_extra: got d=%0d ovf=%b required d=255 ovf=1", r_dat_s, ovf_s[3]);
        end
        checks++;
        if (r_dat_a !== 8'd49) begin
            errors++; $display("FAIL wrap_bank_ch3_untouched: got %0d required 49", r_dat_a);
        end
    endtask

    task automatic test_clr_inc();
        inc_a = 4'b0010;
        repeat (3) tick();
        inc_a = '0;
        rd(2'd1);
        checks++;
        if (r_dat_a !== 8'd20) begin
            errors++; $display("FAIL pre_clr_value: got %0d required 20", r_dat_a);
        end
        inc_a = 4'b0010;
        clr_a = 4'b0010;
        tick();
        inc_a = '0;
        clr_a = '0;
        rd(2'd1);
        checks++;
        if (r_dat_a !== 8'd17) begin
            errors++; $display("FAIL clr_beats_inc: got %0d required 17", r_dat_a);
        end
    endtask

    task automatic test_back_to_back();
        rd_req   = 1'b1;
        rd_idx   = 2'd2;
        rd_ready = 1'b0;
        inc_a    = 4'b0100;
        tick();
        checks++;
        if (vld_a !== 1'b1 || dat_a !== 8'd33) begin
            errors++; $display("FAIL hold_capture: got v=%b d=%0d required v=1 d=33", vld_a, dat_a);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (vld_a !== 1'b1 || dat_a !== 8'd33) begin
                errors++; $display("FAIL hold_stable[%0d]: got v=%b d=%0d required v=1 d=33", i, vld_a, dat_a);
            end
        end
        inc_a    = '0;
        rd_ready = 1'b1;
        tick();
        checks++;
        if (vld_a !== 1'b1 || dat_a !== 8'd38) begin
            errors++; $display("FAIL back_to_back: got v=%b d=%0d required v=1 d=38", vld_a, dat_a);
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (vld_a !== 1'b0 || dat_a !== 8'd38) begin
            errors++; $display("FAIL b2b_release: got v=%b d=%0d required v=0 d=38", vld_a, dat_a);
        end
    endtask

    task automatic test_range_reset();
        rd(2'd3);
        checks++;
        if (r_vld_3 !== 1'b1 || r_err_3 !== 1'b1 || r_dat_3 !== 8'd0) begin
            errors++; $display("FAIL oob_read: got v=%b e=%b d=%0d required v=1 e=1 d=0", r_vld_3, r_err_3, r_dat_3);
        end
        checks++;
        if (r_err_a !== 1'b0) begin
            errors++; $display("FAIL inrange_err: got %b required 0", r_err_a);
        end
        rd(2'd2);
        checks++;
        if (r_err_3 !== 1'b0 || r_dat_3 !== 8'd33) begin
            errors++; $display("FAIL nch3_read2: got e=%b d=%0d required e=0 d=33", r_err_3, r_dat_3);
        end
        rd_req   = 1'b1;
        rd_idx   = 2'd3;
        rd_ready = 1'b0;
        tick();
        rd_req = 1'b0;
        checks++;
        if (vld_3 !== 1'b1 || err_3 !== 1'b1) begin
            errors++; $display("FAIL oob_hold: got v=%b e=%b required v=1 e=1", vld_3, err_3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vld_3 !== 1'b0 || err_3 !== 1'b0 || vld_a !== 1'b0) begin
            errors++; $display("FAIL async_reset: got v3=%b e3=%b va=%b required 0 0 0", vld_3, err_3, vld_a);
        end
        tick();
        rst_n = 1'b1;
        tick();
        rd(2'd0);
        checks++;
        if (r_dat_a !== 8'd1 || r_dat_s !== 8'd1 || ovf_s !== 4'b0000) begin
            errors++; $display("FAIL post_reset: got a=%0d s=%0d ovf=%b required 1 1 0000", r_dat_a, r_dat_s, ovf_s);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_clr_inc();
        test_back_to_back();
        test_range_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
